// File: rtl/eth_axis_frame_arbiter_128b.sv
// eth_axis_frame_arbiter_128b: frame-granular round-robin arbiter with beat watchdog for 128-bit AXI-Stream
module eth_axis_frame_arbiter_128b #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_BEATS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS*128-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*16-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]     s_axis_tvalid,
    output logic [NUM_PORTS-1:0]     s_axis_tready,
    input  logic [NUM_PORTS-1:0]     s_axis_tlast,
    output logic [127:0]             m_axis_tdata,
    output logic [15:0]              m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [NUM_PORTS-1:0]     grant,
    output logic                     trunc_pulse,
    output logic [2:0]               trunc_port
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                 state;
    logic [IW-1:0]          g_idx, rr_ptr, off, pick, nxt;
    logic [IW:0]            sum;
    logic [CW-1:0]          beat_cnt;
    logic [2*NUM_PORTS-1:0] req2;
    logic [127:0]           data_a [NUM_PORTS];
    logic [15:0]            keep_a [NUM_PORTS];
    logic                   fwd, drop, force_last, in_last, in_valid;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_split
        assign data_a[i] = s_axis_tdata[i*128 +: 128];
        assign keep_a[i] = s_axis_tkeep[i*16 +: 16];
    end

    assign fwd        = state == FWD;
    assign drop       = state == DROP;
    assign in_last    = s_axis_tlast[g_idx];
    assign in_valid   = s_axis_tvalid[g_idx];
    assign force_last = fwd && beat_cnt == CW'(MAX_BEATS - 1);
    assign nxt        = g_idx == IW'(NUM_PORTS - 1) ? '0 : g_idx + 1'b1;
    assign req2       = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr;

    assign m_axis_tdata  = data_a[g_idx];
    assign m_axis_tkeep  = keep_a[g_idx];
    assign m_axis_tvalid = fwd & in_valid;
    assign m_axis_tlast  = fwd & (in_last | force_last);
    assign m_axis_tuser  = force_last & ~in_last;
    assign s_axis_tready = grant & {NUM_PORTS{(fwd & m_axis_tready) | drop}};

    // Rotate requests so rr_ptr sits at bit 0, take the nearest request, rotate the offset back
    always_comb begin
        off = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) if (req2[k]) off = IW'(k);
        sum  = {1'b0, rr_ptr} + {1'b0, off};
        pick = sum >= (IW+1)'(NUM_PORTS) ? IW'(sum - (IW+1)'(NUM_PORTS)) : IW'(sum);
    end

    // Frame FSM: grant held from first beat to tlast; watchdog forces tlast/tuser on beat MAX_BEATS
    always_ff @(posedge clk) begin
        trunc_pulse <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            g_idx      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            trunc_port <= '0;
        end else begin
            case (state)
                IDLE: if (|s_axis_tvalid) begin
                    g_idx <= pick;
                    grant <= NUM_PORTS'(1) << pick;
                    state <= FWD;
                end
                FWD: if (m_axis_tvalid && m_axis_tready) begin
                    if (in_last) begin
                        state    <= IDLE;
                        grant    <= '0;
                        rr_ptr   <= nxt;
                        beat_cnt <= '0;
                    end else if (force_last) begin
                        state       <= DROP;
                        trunc_pulse <= 1'b1;
                        trunc_port  <= 3'(g_idx);
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                DROP: if (in_valid && in_last) begin
                    state    <= IDLE;
                    grant    <= '0;
                    rr_ptr   <= nxt;
                    beat_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_axis_frame_arbiter_128b.sv
// tb_eth_axis_frame_arbiter_128b: table-driven frames with a scoreboard of expected output beats
module tb_eth_axis_frame_arbiter_128b;
    localparam int NP = 2;
    localparam int MB = 8;

    logic            clk = 1'b0, rst = 1'b1;
    logic [NP*128-1:0] s_axis_tdata = '0;
    logic [NP*16-1:0]  s_axis_tkeep = '0;
    logic [NP-1:0]   s_axis_tvalid = '0, s_axis_tlast = '0, s_axis_tready;
    logic [127:0]    m_axis_tdata;
    logic [15:0]     m_axis_tkeep;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tuser, trunc_pulse;
    logic            m_axis_tready = 1'b1;
    logic [NP-1:0]   grant;
    logic [2:0]      trunc_port;

    typedef struct { logic [127:0] d; logic [15:0] k; logic l; } beat_t;
    typedef struct { logic [127:0] d; logic [15:0] k; logic l; logic u; int p; } exp_t;
    typedef struct { int port; int len; bit rnd; int exp_out; int exp_trunc; } vec_t;

    beat_t q0[$], q1[$];
    exp_t  sb[$];
    int    checks = 0, errors = 0, out_total = 0, trunc_total = 0, exp_tport = 0, idle_gap = 0;
    bit    gap_chk = 1'b0, after_last = 1'b0;

    eth_axis_frame_arbiter_128b #(.NUM_PORTS(NP), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant(grant), .trunc_pulse(trunc_pulse), .trunc_port(trunc_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Frame model: beats past MB never appear; beat MB carries tlast, and tuser unless it is the real last
    task automatic load_frame(input int p, input int len);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom, $urandom, $urandom};
            b.k = (i == len - 1) ? 16'($urandom_range(1, 65535)) : 16'hffff;
            b.l = (i == len - 1);
            if (p == 0) q0.push_back(b); else q1.push_back(b);
            if (i < MB) begin
                e.d = b.d; e.k = b.k; e.p = p;
                e.l = b.l || (i == MB - 1);
                e.u = !b.l && (i == MB - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input bit rnd, input string name);
        int cyc = 0;
        while (!(sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && grant == '0) && cyc < 400) begin
            @(posedge clk); #2;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        m_axis_tready = 1'b1;
        if (cyc >= 400) begin
            checks++; errors++;
            $display("FAIL %s: timeout, %0d beats still expected", name, sb.size());
        end
    endtask

    // Source: pop on the handshake seen before the edge, then present the next queued beat
    initial begin
        bit acc0, acc1;
        forever begin
            @(negedge clk);
            acc0 = s_axis_tvalid[0] & s_axis_tready[0];
            acc1 = s_axis_tvalid[1] & s_axis_tready[1];
            @(posedge clk); #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            s_axis_tvalid[0] = q0.size() > 0;
            s_axis_tvalid[1] = q1.size() > 0;
            if (q0.size() > 0) begin s_axis_tdata[127:0] = q0[0].d; s_axis_tkeep[15:0] = q0[0].k; s_axis_tlast[0] = q0[0].l; end
            if (q1.size() > 0) begin s_axis_tdata[255:128] = q1[0].d; s_axis_tkeep[31:16] = q1[0].k; s_axis_tlast[1] = q1[0].l; end
        end
    end

    // Monitor: compare accepted output beats against the scoreboard, readies, grant, truncation, idle gaps
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (trunc_pulse) begin
                trunc_total++;
                check("trunc_port", trunc_port, exp_tport);
            end
            if (m_axis_tvalid) begin
                if (gap_chk && after_last) check("idle_gap", idle_gap, 1);
                after_last = 1'b0;
                if (sb.size() > 0) begin
                    check("s_tready", s_axis_tready, m_axis_tready ? (NP'(1) << sb[0].p) : NP'(0));
                    if (m_axis_tready) begin
                        e = sb.pop_front();
                        out_total++;
                        check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, {e.d, e.k, e.l, e.u});
                        check("grant", grant, NP'(1) << e.p);
                        if (m_axis_tlast) begin after_last = 1'b1; idle_gap = 0; end
                    end
                end else if (m_axis_tready) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got data %h expected no beat", m_axis_tdata);
                end
            end else if (after_last) begin
                idle_gap++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t tbl[8];
        int   ob, tb, c;
        tbl[0] = '{0, 4,  1'b0, 4, 0};
        tbl[1] = '{1, 12, 1'b0, 8, 1};
        tbl[2] = '{0, 8,  1'b0, 8, 0};
        tbl[3] = '{1, 1,  1'b0, 1, 0};
        tbl[4] = '{0, 5,  1'b1, 5, 0};
        tbl[5] = '{1, 9,  1'b0, 8, 1};
        tbl[6] = '{0, 2,  1'b1, 2, 0};
        tbl[7] = '{1, 3,  1'b1, 3, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tuser", m_axis_tuser, 0);
        check("rst_trunc", trunc_pulse, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ob = out_total; tb = trunc_total; exp_tport = tbl[i].port;
            load_frame(tbl[i].port, tbl[i].len);
            wait_done(tbl[i].rnd, "frame");
            @(negedge clk);
            check("out_beats", out_total - ob, tbl[i].exp_out);
            check("trunc_cnt", trunc_total - tb, tbl[i].exp_trunc);
            check("grant_idle", grant, 0);
        end
        after_last = 1'b0; gap_chk = 1'b1; ob = out_total; tb = trunc_total;
        load_frame(0, 3); load_frame(1, 3); load_frame(0, 3); load_frame(1, 3);
        wait_done(1'b0, "round_robin");
        @(negedge clk);
        gap_chk = 1'b0;
        check("rr_beats", out_total - ob, 12);
        check("rr_trunc", trunc_total - tb, 0);
        load_frame(0, 1);
        wait_done(1'b0, "pre_reset");
        load_frame(0, 6);
        c = 0;
        while (sb.size() > 4 && c < 100) begin @(posedge clk); #2; c++; end
        if (c >= 100) begin checks++; errors++; $display("FAIL mid_frame: got %0d beats pending expected 4", sb.size()); end
        m_axis_tready = 1'b0; rst = 1'b1;
        q0.delete(); q1.delete(); sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_s_tready", s_axis_tready, 0);
        check("mid_rst_m_tvalid", m_axis_tvalid, 0);
        @(posedge clk); #2;
        rst = 1'b0; m_axis_tready = 1'b1; ob = out_total;
        load_frame(0, 2); load_frame(1, 2);
        wait_done(1'b0, "post_reset");
        @(negedge clk);
        check("post_rst_beats", out_total - ob, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
